onehottobin_stream: RTL and testbench
=====================================

// Module: onehottobin_stream
// PURPOSE
//  Streaming one-hot -> binary encoder; inverse of the binary-to-one-hot block.
//  Accepts N-bit one-hot words on a valid/ready input and emits the binary index
//  plus an error flag for illegal codes (zero-hot or multi-hot) on a valid/ready output.
//  A 2-entry output buffer decouples the two handshakes. Sits between one-hot
//  request sources (arbiters, decoders) and binary-index consumers.
// PARAMETERS
//  N          16   one-hot input width; N >= 2
//  W          $clog2(N) (4)  binary output width; derived, do not override
//  ERR_CNT_W  8    error-counter width; used only with ONEHOT_ERR_CNT_EN
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input word valid
//  in_ready   out  1          block can accept a word this cycle
//  in_onehot  in   N          one-hot input word
//  out_valid  out  1          output entry valid
//  out_ready  in   1          consumer accepts output this cycle
//  out_bin    out  W          binary index of the head entry
//  out_err    out  1          head entry came from an illegal code
//  err_cnt    out  ERR_CNT_W  saturating illegal-code count (ONEHOT_ERR_CNT_EN only)
// BEHAVIOUR
//  - All state updates on rising clk edge. rst has priority over all other inputs.
//  - Reset values: out_valid=0, out_bin=0, out_err=0, err_cnt=0, occupancy=0, in_ready=1.
//  - Transfers: push when in_valid && in_ready; pop when out_valid && out_ready.
//  - Encode, combinational on in_onehot:
//    exactly one bit k set     -> bin=k, err=0
//    zero bits set             -> bin=0, err=1
//    >1 bits set               -> bin=lowest set index, err=1
//  - Latency: a word pushed at edge t appears at out_* after edge t if the buffer
//    was empty. No combinational path from in_* to out_*.
//  - Buffer FSM (occupancy): EMPTY(0), ONE(1), FULL(2).
//    EMPTY: push -> ONE; else stay.
//    ONE:   push&&!pop -> FULL; pop&&!push -> EMPTY; push&&pop -> ONE (new word at head).
//    FULL:  pop -> ONE; push is impossible.
//  - in_ready = (state != FULL); registered decode only, never depends on out_ready.
//  - out_valid = (state != EMPTY). Head = oldest entry; strict FIFO order.
//  - While out_valid && !out_ready, out_bin/out_err hold stable.
//  - in_onehot is don't-care when in_valid=0; no push, no error counted.
//  - rst asserted mid-stream: both entries discarded; out_valid=0 on the following cycle.
// CONFIGURATION
//  ONEHOT_ERR_CNT_EN defined:
//   - err_cnt port exists; increments by 1 on each push whose err=1.
//   - Saturates at 2**ERR_CNT_W-1; never wraps. Cleared only by rst.
//   - Counts at push time, independent of whether the entry is ever popped.
//  ONEHOT_ERR_CNT_EN undefined:
//   - err_cnt port and counter absent; out_err still generated per entry.
// TESTING
//  T1 reset: hold rst 2 cycles -> out_valid=0, out_bin=0, out_err=0, in_ready=1, err_cnt=0.
//  T2 sweep: out_ready=1, push 16'h0001<<k for k=0..15 back-to-back -> out_bin=k,
//     out_err=0, one cycle after each push, in_ready stays 1.
//  T3 illegal: push 16'h0000 -> bin=0, err=1; push 16'h0120 -> bin=5, err=1;
//     with ONEHOT_ERR_CNT_EN, err_cnt=2.
//  T4 backpressure: out_ready=0, push 16'h0004, 16'h0800 -> in_ready=0 after 2nd push,
//     out_bin=2 stable; raise out_ready -> out_bin=2 then 11, in_ready=1 after first pop.
//  T5 simultaneous: state ONE (head 16'h0002), push 16'h8000 with out_ready=1 ->
//     pop bin=1, next cycle out_bin=15, state ONE.
//  T6 saturation/reset: ERR_CNT_W=2, push 5 zero words -> err_cnt=3;
//     assert rst with FULL buffer -> out_valid=0, err_cnt=0 next cycle.

Source files
------------

// File: rtl/onehottobin_stream.sv
// Streaming one-hot to binary encoder with a 2-entry output buffer between the handshakes.
// Optional saturating illegal-code counter on err_cnt when ONEHOT_ERR_CNT_EN is defined.
module onehottobin_stream #(
    parameter int N         = 16,
    parameter int W         = $clog2(N),
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_onehot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_bin,
    output logic                 out_err
`ifdef ONEHOT_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Returns {err, bin}: lowest set index, err for zero-hot or multi-hot words.
    function automatic logic [W:0] encode(input logic [N-1:0] v);
        logic [W-1:0] b;
        logic         found;
        logic         multi;
        b     = {W{1'b0}};
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    b     = W'(i);
                    found = 1'b1;
                end
            end
        end
        return {(~found) | multi, b};
    endfunction

    state_t         state_r;
    state_t         state_nx_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [W-1:0]   head_bin_r;
    logic           head_err_r;
    logic [W-1:0]   tail_bin_r;
    logic           tail_err_r;
    logic [W:0]     enc_s;
    logic           push_s;
    logic           pop_s;
    logic           head_ld_s;
    logic           head_from_tail_s;
    logic           tail_ld_s;

    assign enc_s  = encode(in_onehot);
    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Occupancy next-state and buffer load strobes.
    always_comb begin
        state_nx_s       = state_r;
        head_ld_s        = 1'b0;
        head_from_tail_s = 1'b0;
        tail_ld_s        = 1'b0;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    head_ld_s  = 1'b1;
                    state_nx_s = ONE;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    head_ld_s  = 1'b1;
                    state_nx_s = ONE;
                end else if (push_s) begin
                    tail_ld_s  = 1'b1;
                    state_nx_s = FULL;
                end else if (pop_s) begin
                    state_nx_s = EMPTY;
                end else begin
                    state_nx_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    head_from_tail_s = 1'b1;
                    state_nx_s       = ONE;
                end else begin
                    state_nx_s = FULL;
                end
            end
            default: begin
                state_nx_s = EMPTY;
            end
        endcase
    end

    // State, handshake flags and buffer entries; flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_bin_r  <= {W{1'b0}};
            head_err_r  <= 1'b0;
            tail_bin_r  <= {W{1'b0}};
            tail_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != FULL);
            out_valid_r <= (state_nx_s != EMPTY);
            if (head_ld_s) begin
                head_bin_r <= enc_s[W-1:0];
                head_err_r <= enc_s[W];
            end else if (head_from_tail_s) begin
                head_bin_r <= tail_bin_r;
                head_err_r <= tail_err_r;
            end else begin
                head_bin_r <= head_bin_r;
                head_err_r <= head_err_r;
            end
            if (tail_ld_s) begin
                tail_bin_r <= enc_s[W-1:0];
                tail_err_r <= enc_s[W];
            end else begin
                tail_bin_r <= tail_bin_r;
                tail_err_r <= tail_err_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bin   = head_bin_r;
    assign out_err   = head_err_r;

`ifdef ONEHOT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Counts illegal words at push time and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (push_s && enc_s[W] && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_onehottobin_stream.sv
// Table-driven bench for onehottobin_stream plus directed backpressure, overlap and reset sequences.
module tb_onehottobin_stream;

    localparam int N = 16;
    localparam int W = 4;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_onehot;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_bin;
    logic          out_err;
`ifdef ONEHOT_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         vld;
        logic [N-1:0] oh;
        logic         rdy;
        logic         exp_vld;
        logic [W-1:0] exp_bin;
        logic         exp_err;
    } vec_t;

    vec_t tbl[$];

    onehottobin_stream #(.N(N), .ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_onehot (in_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
`ifdef ONEHOT_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] oh, input logic r);
        in_valid  = v;
        in_onehot = oh;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bin", out_bin, 4'd0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef ONEHOT_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 2'd0);
`endif
        rst = 1'b0;

        // Sweep, illegal codes, then idle cycles with garbage on in_onehot
        for (int k = 0; k < N; k++) begin
            tbl.push_back('{1'b1, 16'h0001 << k, 1'b1, 1'b1, W'(k), 1'b0});
        end
        tbl.push_back('{1'b1, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1});
        tbl.push_back('{1'b1, 16'h0120, 1'b1, 1'b1, 4'd5, 1'b1});
        tbl.push_back('{1'b1, 16'hC000, 1'b1, 1'b1, 4'd14, 1'b1});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0});

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].oh, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
            if (tbl[i].exp_vld) begin
                chk($sformatf("tbl%0d_bin", i), out_bin, tbl[i].exp_bin);
                chk($sformatf("tbl%0d_err", i), out_err, tbl[i].exp_err);
            end
        end
`ifdef ONEHOT_ERR_CNT_EN
        chk("illegal_err_cnt", err_cnt, 2'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        // Backpressure: fill, ignore a word while full, then drain in order
        drive(1'b1, 16'h0004, 1'b0);
        tick();
        chk("bp1_bin", out_bin, 4'd2);
        chk("bp1_in_ready", in_ready, 1'b1);
        drive(1'b1, 16'h0800, 1'b0);
        tick();
        chk("bp2_in_ready", in_ready, 1'b0);
        chk("bp2_bin", out_bin, 4'd2);
        drive(1'b1, 16'h0001, 1'b0);
        tick();
        chk("bp_hold_bin", out_bin, 4'd2);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_in_ready", in_ready, 1'b0);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        chk("bp_pop1_bin", out_bin, 4'd11);
        chk("bp_pop1_in_ready", in_ready, 1'b1);
        tick();
        chk("bp_pop2_valid", out_valid, 1'b0);

        // Simultaneous push and pop in ONE
        drive(1'b1, 16'h0002, 1'b0);
        tick();
        drive(1'b1, 16'h8000, 1'b1);
        chk("sim_head_bin", out_bin, 4'd1);
        tick();
        chk("sim_new_bin", out_bin, 4'd15);
        chk("sim_valid", out_valid, 1'b1);
        chk("sim_in_ready", in_ready, 1'b1);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        chk("sim_drained", out_valid, 1'b0);

        // Saturation, then reset with a full buffer
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0000, 1'b1);
            tick();
        end
        chk("sat_err", out_err, 1'b1);
`ifdef ONEHOT_ERR_CNT_EN
        chk("sat_err_cnt", err_cnt, 2'd3);
`endif
        drive(1'b1, 16'h0010, 1'b0);
        tick();
        drive(1'b1, 16'h0040, 1'b0);
        tick();
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_bin", out_bin, 4'd0);
        chk("mrst_err", out_err, 1'b0);
`ifdef ONEHOT_ERR_CNT_EN
        chk("mrst_err_cnt", err_cnt, 2'd0);
`endif
        tick();
        chk("post_rst_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
